// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch-stage controller. Selects the next PC and drives the
//               IF/ID and ID/EX pipeline controls, arbitrating between
//               sequential fetch, ID-stage redirects, load-use stalls,
//               memory freezes and halt. Sequences a boot phase after reset
//               and keeps saturating stall/redirect counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          BOOT_CYCLES  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        load_use_i,
    input  logic        mem_stall_i,
    input  logic        halt_i,
    output logic        pc_write_o,
    output logic [31:0] pc_next_o,
    output logic        if_id_write_o,
    output logic        if_id_flush_o,
    output logic        id_ex_bubble_o,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] redirect_cnt_o
);

    localparam logic [1:0]  c_ST_BOOT   = 2'd0;
    localparam logic [1:0]  c_ST_RUN    = 2'd1;
    localparam logic [1:0]  c_ST_HALT   = 2'd2;
    localparam logic [3:0]  c_BOOT_LAST = 4'(BOOT_CYCLES - 1);
    localparam logic [15:0] c_CNT_MAX   = 16'hFFFF;

    logic [1:0]  r_state;
    logic [3:0]  r_boot_cnt;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_redirect_cnt;

    logic [31:0] w_pc_plus4;
    logic        w_stall;
    logic        w_redirect;

    assign w_pc_plus4 = pc_i + 32'd4;

    // A stall or redirect only takes effect in RUN; stalls outrank redirects
    // because the branch operands are not valid during a hazard.
    assign w_stall    = (r_state == c_ST_RUN) && (mem_stall_i || load_use_i);
    assign w_redirect = (r_state == c_ST_RUN) && !mem_stall_i && !load_use_i
                        && (jump_i || branch_taken_i);

    // Mealy control: PC and pipeline registers act on the same edge as the decision.
    always_comb begin
        pc_write_o     = 1'b0;
        pc_next_o      = w_pc_plus4;
        if_id_write_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        if (rst_i || (r_state == c_ST_BOOT)) begin
            pc_write_o     = 1'b1;
            pc_next_o      = RESET_VECTOR;
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
        end else if (r_state == c_ST_HALT) begin
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
        end else if (r_state == c_ST_RUN) begin
            if (mem_stall_i) begin
                // whole front end frozen: everything holds
            end else if (load_use_i) begin
                id_ex_bubble_o = 1'b1;
            end else if (jump_i) begin
                pc_write_o    = 1'b1;
                pc_next_o     = jump_target_i;
                if_id_write_o = 1'b1;
                if_id_flush_o = 1'b1;
            end else if (branch_taken_i) begin
                pc_write_o    = 1'b1;
                pc_next_o     = branch_target_i;
                if_id_write_o = 1'b1;
                if_id_flush_o = 1'b1;
            end else if (halt_i) begin
                if_id_flush_o = 1'b1;
            end else begin
                pc_write_o    = 1'b1;
                if_id_write_o = 1'b1;
            end
        end
    end

    // FSM: boot countdown, run, halt; the unused encoding falls back to BOOT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_ST_BOOT;
            r_boot_cnt <= 4'd0;
        end else begin
            case (r_state)
                c_ST_BOOT: begin
                    r_boot_cnt <= r_boot_cnt + 4'd1;
                    if (r_boot_cnt == c_BOOT_LAST) begin
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (!mem_stall_i && !load_use_i && !jump_i &&
                        !branch_taken_i && halt_i) begin
                        r_state <= c_ST_HALT;
                    end
                end
                c_ST_HALT: begin
                    r_state <= c_ST_HALT;
                end
                default: begin
                    r_state    <= c_ST_BOOT;
                    r_boot_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Saturating performance counters, advancing only in RUN.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt    <= 16'd0;
            r_redirect_cnt <= 16'd0;
        end else begin
            if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_redirect && (r_redirect_cnt != c_CNT_MAX)) begin
                r_redirect_cnt <= r_redirect_cnt + 16'd1;
            end
        end
    end

    assign state_o        = r_state;
    assign stall_cnt_o    = r_stall_cnt;
    assign redirect_cnt_o = r_redirect_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed testbench for pc_sequencer with a behavioural model
//               checked every cycle plus hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int c_BOOT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = 32'd0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = 32'd0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_target_i = 32'd0;
    logic        load_use_i = 1'b0;
    logic        mem_stall_i = 1'b0;
    logic        halt_i = 1'b0;
    logic        pc_write_o;
    logic [31:0] pc_next_o;
    logic        if_id_write_o;
    logic        if_id_flush_o;
    logic        id_ex_bubble_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] redirect_cnt_o;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model state: 0 boot, 1 run, 2 halt
    int m_mode  = 0;
    int m_boot  = 0;
    int m_stall = 0;
    int m_redir = 0;

    pc_sequencer #(
        .RESET_VECTOR(32'h0000_0000),
        .BOOT_CYCLES (c_BOOT)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .pc_i           (pc_i),
        .branch_taken_i (branch_taken_i),
        .branch_target_i(branch_target_i),
        .jump_i         (jump_i),
        .jump_target_i  (jump_target_i),
        .load_use_i     (load_use_i),
        .mem_stall_i    (mem_stall_i),
        .halt_i         (halt_i),
        .pc_write_o     (pc_write_o),
        .pc_next_o      (pc_next_o),
        .if_id_write_o  (if_id_write_o),
        .if_id_flush_o  (if_id_flush_o),
        .id_ex_bubble_o (id_ex_bubble_o),
        .state_o        (state_o),
        .stall_cnt_o    (stall_cnt_o),
        .redirect_cnt_o (redirect_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model advance on the active edge, from the rules for each mode.
    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_boot = 0; m_stall = 0; m_redir = 0;
        end else if (m_mode == 0) begin
            m_boot = m_boot + 1;
            if (m_boot == c_BOOT) m_mode = 1;
        end else if (m_mode == 1) begin
            if (mem_stall_i || load_use_i) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
            else if (jump_i || branch_taken_i) m_redir = (m_redir < 65535) ? m_redir + 1 : 65535;
            else if (halt_i) m_mode = 2;
        end
    end

    // Every-cycle comparison against the model at mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic        e_pw, e_iw, e_fl, e_bb;
            logic [31:0] e_nx;
            e_pw = 0; e_iw = 0; e_fl = 0; e_bb = 0;
            e_nx = pc_i + 32'd4;
            if (rst || m_mode == 0) begin
                e_pw = 1; e_nx = 32'h0; e_fl = 1; e_bb = 1;
            end else if (m_mode == 2) begin
                e_fl = 1; e_bb = 1;
            end else if (mem_stall_i) begin
            end else if (load_use_i) begin
                e_bb = 1;
            end else if (jump_i) begin
                e_pw = 1; e_iw = 1; e_fl = 1; e_nx = jump_target_i;
            end else if (branch_taken_i) begin
                e_pw = 1; e_iw = 1; e_fl = 1; e_nx = branch_target_i;
            end else if (halt_i) begin
                e_fl = 1;
            end else begin
                e_pw = 1; e_iw = 1;
            end
            chk("m_pc_write", {31'd0, pc_write_o}, {31'd0, e_pw});
            chk("m_pc_next", pc_next_o, e_nx);
            chk("m_if_id_write", {31'd0, if_id_write_o}, {31'd0, e_iw});
            chk("m_if_id_flush", {31'd0, if_id_flush_o}, {31'd0, e_fl});
            chk("m_id_ex_bubble", {31'd0, id_ex_bubble_o}, {31'd0, e_bb});
            chk("m_state", {30'd0, state_o}, 32'(m_mode));
            chk("m_stall_cnt", {16'd0, stall_cnt_o}, 32'(m_stall));
            chk("m_redirect_cnt", {16'd0, redirect_cnt_o}, 32'(m_redir));
        end
    end

    initial begin
        // 1. reset and boot
        #1;
        chk("rst_pc_write", {31'd0, pc_write_o}, 32'd1);
        chk("rst_pc_next", pc_next_o, 32'h0);
        step();
        cmp_en = 1'b1;
        rst = 1'b0;
        #1;
        chk("boot0_state", {30'd0, state_o}, 32'd0);
        chk("boot0_pc_write", {31'd0, pc_write_o}, 32'd1);
        chk("boot0_pc_next", pc_next_o, 32'h0);
        step();
        chk("boot1_state", {30'd0, state_o}, 32'd0);
        chk("boot1_pc_next", pc_next_o, 32'h0);
        step();
        chk("run_state", {30'd0, state_o}, 32'd1);
        chk("run_pc_next0", pc_next_o, 32'h4);

        // 2. sequential fetch and wrap
        pc_i = 32'h0000_0010; #1;
        chk("seq_pc_next", pc_next_o, 32'h14);
        chk("seq_pc_write", {31'd0, pc_write_o}, 32'd1);
        step();
        pc_i = 32'hFFFF_FFFC; #1;
        chk("wrap_pc_next", pc_next_o, 32'h0);
        step();

        // 3. jump beats branch
        jump_i = 1; jump_target_i = 32'h100;
        branch_taken_i = 1; branch_target_i = 32'h200; #1;
        chk("jmp_pc_next", pc_next_o, 32'h100);
        chk("jmp_flush", {31'd0, if_id_flush_o}, 32'd1);
        step();
        chk("jmp_redir_cnt", {16'd0, redirect_cnt_o}, 32'd1);

        // 3b. lone branch
        jump_i = 0; #1;
        chk("br_pc_next", pc_next_o, 32'h200);
        step();
        chk("br_redir_cnt", {16'd0, redirect_cnt_o}, 32'd2);

        // 4. load-use beats branch, then mem stall beats load-use
        load_use_i = 1; #1;
        chk("lu_pc_write", {31'd0, pc_write_o}, 32'd0);
        chk("lu_bubble", {31'd0, id_ex_bubble_o}, 32'd1);
        step();
        chk("lu_redir_cnt", {16'd0, redirect_cnt_o}, 32'd2);
        chk("lu_stall_cnt", {16'd0, stall_cnt_o}, 32'd1);
        mem_stall_i = 1; #1;
        chk("ms_bubble", {31'd0, id_ex_bubble_o}, 32'd0);
        chk("ms_if_id_write", {31'd0, if_id_write_o}, 32'd0);
        step();
        chk("ms_stall_cnt", {16'd0, stall_cnt_o}, 32'd2);

        // 5. halt, ignored jump, reset out of halt
        mem_stall_i = 0; load_use_i = 0; branch_taken_i = 0;
        halt_i = 1; #1;
        chk("halt_flush", {31'd0, if_id_flush_o}, 32'd1);
        chk("halt_pc_write_run", {31'd0, pc_write_o}, 32'd0);
        step();
        halt_i = 0;
        chk("halt_state", {30'd0, state_o}, 32'd2);
        jump_i = 1; #1;
        chk("halt_pc_write", {31'd0, pc_write_o}, 32'd0);
        step();
        jump_i = 0;
        chk("halt_state_hold", {30'd0, state_o}, 32'd2);
        chk("halt_redir_frozen", {16'd0, redirect_cnt_o}, 32'd2);
        rst = 1; #1;
        chk("halt_rst_pc_write", {31'd0, pc_write_o}, 32'd1);
        step();
        rst = 0;
        chk("halt_rst_state", {30'd0, state_o}, 32'd0);
        chk("halt_rst_stall", {16'd0, stall_cnt_o}, 32'd0);
        chk("halt_rst_redir", {16'd0, redirect_cnt_o}, 32'd0);

        // 6. saturation and mid-stall reset
        step(); step();
        chk("sat_run_state", {30'd0, state_o}, 32'd1);
        mem_stall_i = 1;
        for (int i = 0; i < 65540; i++) step();
        chk("sat_stall_cnt", {16'd0, stall_cnt_o}, 32'h0000_FFFF);
        rst = 1; #1;
        chk("midrst_pc_write", {31'd0, pc_write_o}, 32'd1);
        chk("midrst_pc_next", pc_next_o, 32'h0);
        step();
        rst = 0; mem_stall_i = 0;
        chk("midrst_stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
        step(); step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
